// File: rtl/tdm_demux_1to4_if.sv
// TDM demux bus: shared sample stream in, four rebuilt channels out.
// Master drives samples, slave (the demux) drives channels and status.
interface tdm_demux_1to4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             fsync;
    logic [WIDTH-1:0] Y0;
    logic [WIDTH-1:0] Y1;
    logic [WIDTH-1:0] Y2;
    logic [WIDTH-1:0] Y3;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;

    modport master (
        output din, din_valid, fsync,
        input  Y0, Y1, Y2, Y3, frame_valid, locked, sync_err
    );

    modport slave (
        input  din, din_valid, fsync,
        output Y0, Y1, Y2, Y3, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux_1to4.sv
// 4-slot TDM receive demux: rebuilds channels from a framed sample stream
// and publishes all four together once per complete frame.
module tdm_demux_1to4 #(
    parameter int WIDTH = 1
) (
    input logic              clk,
    input logic              rst_n,
    tdm_demux_1to4_if.slave  bus_s
);
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] s0_q, s0_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;
    logic [WIDTH-1:0] y2_q, y2_d;
    logic [WIDTH-1:0] y3_q, y3_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;

    logic early_sync;
    logic miss_sync;
    logic last_slot;

    assign early_sync = bus_s.fsync && (slot_q != 2'd0);
    assign miss_sync  = !bus_s.fsync && (slot_q == 2'd0);
    assign last_slot  = !bus_s.fsync && (slot_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus_s.din_valid) begin
            unique case (state_q)
                HUNT:    if (bus_s.fsync) state_d = LOCKED;
                LOCKED:  if (miss_sync) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        slot_d = slot_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        y0_d   = y0_q;
        y1_d   = y1_q;
        y2_d   = y2_q;
        y3_d   = y3_q;
        fv_d   = 1'b0;
        err_d  = 1'b0;
        if (bus_s.din_valid) begin
            if (state_q == HUNT) begin
                if (bus_s.fsync) begin
                    s0_d   = bus_s.din;
                    slot_d = 2'd1;
                end
            end else begin
                // Early sync resyncs on the same edge, so the lock holds.
                unique case (1'b1)
                    early_sync: begin
                        err_d  = 1'b1;
                        s0_d   = bus_s.din;
                        slot_d = 2'd1;
                    end
                    miss_sync: begin
                        err_d  = 1'b1;
                        slot_d = 2'd0;
                    end
                    last_slot: begin
                        y0_d   = s0_q;
                        y1_d   = s1_q;
                        y2_d   = s2_q;
                        y3_d   = bus_s.din;
                        fv_d   = 1'b1;
                        slot_d = 2'd0;
                    end
                    default: begin
                        unique case (slot_q)
                            2'd0:    s0_d = bus_s.din;
                            2'd1:    s1_d = bus_s.din;
                            default: s2_d = bus_s.din;
                        endcase
                        slot_d = slot_q + 2'd1;
                    end
                endcase
            end
        end
    end

    assign bus_s.Y0          = y0_q;
    assign bus_s.Y1          = y1_q;
    assign bus_s.Y2          = y2_q;
    assign bus_s.Y3          = y3_q;
    assign bus_s.frame_valid = fv_q;
    assign bus_s.sync_err    = err_q;
    assign bus_s.locked      = (state_q == LOCKED);
endmodule

// File: doc/tdm_demux_1to4.md
# tdm_demux_1to4

Time-division demultiplexer: the receive end of the 4-slot select/merge path. It takes one shared sample stream in which consecutive valid samples occupy slots 0, 1, 2 and 3, with slot 0 marked by a frame-sync flag. It rebuilds the four channels as registered parallel outputs and publishes all four together, once per frame. It sits downstream of the 4-to-1 selection stage, where the slot index drives the select lines.

## Interface
Parameters:
- WIDTH, 1: bits per sample and per channel output.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst_n  input  1  reset, asynchronous and active-low.
- din  input  WIDTH  shared sample bus.
- din_valid  input  1  din carries a sample this cycle.
- fsync  input  1  qualified by din_valid; this sample is slot 0.
- Y0, Y1, Y2, Y3  output  WIDTH each  registered channel outputs (slot 0..3).
- frame_valid  output  1  one-cycle pulse: Y0..Y3 were just updated with a complete frame.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing violation.

## Operation
- A sample is accepted on a rising edge only when din_valid=1. din_valid=0 cycles are gaps: no state, counter or register change, and frame_valid and sync_err are 0.
- Internal state:
  - 2-bit slot counter `slot`.
  - Shadow registers S0..S2, each WIDTH bits.
  - FSM with states HUNT and LOCKED.
- HUNT:
  - A sample with fsync=0 is discarded.
  - A sample with fsync=1 is stored in S0, slot becomes 1, and the FSM moves to LOCKED.
- LOCKED, accepted sample, checked in this order:
  - fsync=1 and slot≠0 (early sync, i.e. a short frame): pulse sync_err. The partial frame is discarded with no output update. The sample is stored in S0, slot becomes 1, and the FSM stays LOCKED (immediate resync).
  - fsync=0 and slot=0 (missing sync): pulse sync_err. The sample is discarded and the FSM moves to HUNT. slot is held at 0.
  - slot=0..2, no violation: the sample is stored in S[slot] and slot increments.
  - slot=3, no violation: Y0←S0, Y1←S1, Y2←S2 and Y3←din, all on the same edge. frame_valid pulses and slot wraps to 0.
- Y0..Y3 hold their values between frames and are never partially updated.
- A discarded or partial frame never reaches the outputs.
- Arithmetic: slot is modulo-4. No other arithmetic. Samples pass through bit-exact.

## Timing
- Reset (asynchronous assert; release synchronous to clk):
  - Y0..Y3=0, frame_valid=0, sync_err=0, locked=0.
  - FSM=HUNT, slot=0, S0..S2=0.
- Reset asserted mid-frame aborts that frame immediately. No frame_valid is produced for it.
- After rst_n deasserts, the first edge with din_valid=1 and fsync=1 is the earliest frame start.
- Latency: on the edge that accepts the slot-3 sample, Y0..Y3 update and frame_valid goes high for exactly one cycle. With no gaps, frame_valid is 1 cycle after slot 3 is presented and 4 cycles after slot 0 is presented.
- Back-to-back frames give at most one frame_valid every 4 cycles. Gaps stretch the frame without limit.
- locked is registered. It rises on the edge that accepts the first fsync sample in HUNT. It falls on the edge that detects a missing sync.
- sync_err is registered and high for one cycle after the violating edge.
- An early-sync error and the resync happen on the same edge, so locked stays 1.
- All outputs are driven from flops. There is no combinational din→Y path.

## Test plan
- Reset: hold rst_n=0 while driving traffic. Required: all outputs 0, locked=0. Then assert rst_n=0 asynchronously, between clock edges, in the middle of a LOCKED frame. Required: outputs clear at once, no frame_valid for that frame.
- Basic frame, WIDTH=4, no gaps: from HUNT, send A(fsync), B, C, D. Required: locked=1 after the A edge. After the D edge, Y0..Y3=A,B,C,D and frame_valid=1 for 1 cycle. Y0..Y3 hold afterwards.
- Gaps and back-to-back frames: send 1,2,3,4 then 5,6,7,8, with din_valid=0 inserted randomly between samples. Required: exactly two frame_valid pulses, outputs 1,2,3,4 then 5,6,7,8, and no change to outputs during gaps.
- Early sync: send 1(fs), 2, then 9(fs), A, B, C. Required: sync_err pulses on the 9 edge, locked stays 1, no output update for 1,2, and the next frame outputs 9,A,B,C.
- Missing sync: complete a frame, then send 5 with fsync=0 as the next slot-0 sample. Required: sync_err pulses, locked falls to 0, and subsequent fsync=0 samples are ignored. Recovery with 1(fs),2,3,4 outputs 1,2,3,4.
- HUNT discard: after reset send 7,7,7 with fsync=0, then 1(fs),2,3,4. Required: no frame_valid, Y0..Y3 stay 0 until the frame completes, then show 1,2,3,4.
